// File: rtl/seq_div_unit_pkg.sv
// seq_div_unit_pkg
// Shared definitions for the sequential unsigned divider:
//   - default datapath and iteration-counter widths
//   - FSM state encoding
//   - quotient value reported on divide-by-zero
//   - cla4(): 4-bit carry-lookahead adder block, the building unit of the
//     trial subtractor
package seq_div_unit_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    // All-ones quotient returned when the divisor is zero.
    localparam logic [WIDTH_DEF-1:0] DBZ_QUOT = {WIDTH_DEF{1'b1}};

    // 4-bit lookahead adder: returns {carry_out, sum[3:0]}.
    // Every carry is formed directly from generate/propagate terms and the
    // block carry-in, so no carry ripples through the block.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       c4;
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c4, p ^ {c3, c2, c1, cin}};
    endfunction

endpackage

// File: rtl/seq_div_unit_if.sv
// seq_div_unit_if
// Request/result bundle between the execute stage and the divider.
//   start     : request pulse (master -> divider)
//   dividend  : numerator   (master -> divider)
//   divisor   : denominator (master -> divider)
//   busy      : divider iterating (divider -> master)
//   done      : one-cycle result-valid pulse (divider -> master)
//   quotient  : result, held until the next accepted start
//   remainder : result, held until the next accepted start
//   dbz       : divide-by-zero flag, valid with done and held with results
interface seq_div_unit_if
    import seq_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );

endinterface

// File: rtl/seq_div_unit_sub_cla17.sv
// sub_cla17
// (WIDTH+1)-bit subtractor diff = a - b, formed as a + ~b + 1.
// The low WIDTH bits use 4-bit lookahead blocks chained at group level;
// the top bit is a single carry stage that produces the final carry-out.
// Ports:
//   a_i      : minuend, WIDTH+1 bits
//   b_i      : subtrahend, WIDTH+1 bits
//   diff_o   : difference, WIDTH+1 bits
//   borrow_o : 1 when a_i < b_i (inverse of the adder carry-out)
// WIDTH must be a multiple of 4.
module sub_cla17
    import seq_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0] a_i,
    input  logic [WIDTH:0] b_i,
    output logic [WIDTH:0] diff_o,
    output logic           borrow_o
);

    localparam int NGRP = WIDTH / 4;

    logic [WIDTH:0] b_inv_s;
    logic [NGRP:0]  grp_c_s;
    logic           top_p_s;
    logic           cout_s;

    assign b_inv_s    = ~b_i;
    // Carry-in of 1 completes the two's-complement negation of b_i.
    assign grp_c_s[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            assign {grp_c_s[gi+1], diff_o[4*gi+3:4*gi]} =
                cla4(a_i[4*gi+3:4*gi], b_inv_s[4*gi+3:4*gi], grp_c_s[gi]);
        end
    endgenerate

    assign top_p_s       = a_i[WIDTH] ^ b_inv_s[WIDTH];
    assign diff_o[WIDTH] = top_p_s ^ grp_c_s[NGRP];
    assign cout_s        = (a_i[WIDTH] & b_inv_s[WIDTH]) | (top_p_s & grp_c_s[NGRP]);
    assign borrow_o      = ~cout_s;

endmodule

// File: rtl/seq_div_unit.sv
// seq_div_unit
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// A nonzero-divisor request takes WIDTH iterations (busy) followed by a
// one-cycle done pulse; a zero divisor skips straight to done with
// quotient = all ones, remainder = dividend and dbz = 1.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   div_if : slave side of seq_div_unit_if (start/operands in, results out)
// All outputs come straight from registers.
// CNT_W must satisfy 2**CNT_W > WIDTH.
module seq_div_unit
    import seq_div_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_div_unit_if.slave  div_if
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;          // partial remainder
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;          // captured divisor
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   r_sh_s;
    logic [WIDTH-1:0] q_sh_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic             take_s;

    // Shift {R,Q} left by one: the MSB of Q becomes the new LSB of R.
    assign r_sh_s = {r_q, q_q[WIDTH-1]};
    assign q_sh_s = {q_q[WIDTH-2:0], 1'b0};

    sub_cla17 #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i      (r_sh_s),
        .b_i      ({1'b0, d_q}),
        .diff_o   (trial_s),
        .borrow_o (borrow_s)
    );

    // Since R < D before the shift, R_shifted < 2*D, so a non-negative trial
    // always fits in WIDTH bits: the carry-out and the trial MSB agree.
    assign take_s = ~borrow_s & ~trial_s[WIDTH];

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (div_if.start) begin
                    if (div_if.divisor != {WIDTH{1'b0}}) begin
                        state_d = S_RUN;
                        d_d     = div_if.divisor;
                        r_d     = {WIDTH{1'b0}};
                        q_d     = div_if.dividend;
                        cnt_d   = CNT_W'(WIDTH);
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        quot_d  = DBZ_QUOT[WIDTH-1:0];
                        rem_d   = div_if.dividend;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                if (take_s) begin
                    r_d = trial_s[WIDTH-1:0];
                    q_d = q_sh_s | {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    r_d = r_sh_s[WIDTH-1:0];
                    q_d = q_sh_s;
                end
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                // Last iteration: publish the results so they appear with done.
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = q_d;
                    rem_d   = r_d;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_FIN: begin
                // Start requests in this cycle are dropped, not queued.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset clears every output immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= {WIDTH{1'b0}};
            q_q     <= {WIDTH{1'b0}};
            d_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign div_if.busy      = busy_q;
    assign div_if.done      = done_q;
    assign div_if.dbz       = dbz_q;
    assign div_if.quotient  = quot_q;
    assign div_if.remainder = rem_q;

endmodule
